// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
package seq_pkg;

    localparam logic [3:0] DEFAULT_PAT = 4'b1011;

    typedef enum bit {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_policy_e;

    // Width needed to hold a fill level of 0..pat_len inclusive.
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with sticky overflow flag; saturates or wraps at all-ones.
module sat_counter
    import seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam bit IS_SAT = (SATURATE == CNT_SAT);

    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (clr) begin
            // Clear wins over a coincident increment.
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (inc) begin
            if (&count_reg) begin
                ovf_reg <= 1'b1;
                if (!IS_SAT) begin
                    count_reg <= '0;
                end
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/seq_match_counter.sv
// Programmable serial pattern detector with overlap control and an occurrence counter.
module seq_match_counter
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN  = 4,
    parameter int                 CNT_W    = 8,
    parameter logic [PAT_LEN-1:0] RST_PAT  = PAT_LEN'(DEFAULT_PAT),
    parameter bit                 SATURATE = 1'b1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clr,
    output logic               match,
    output logic [CNT_W-1:0]   count,
    output logic               ovf
);

    localparam int            FW        = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] hist_reg;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_reg;
    logic [FW-1:0]      fill_next;
    logic               match_reg;
    logic               hit;

    // Newest bit enters at the LSB so the MSB lines up with the first pattern bit.
    assign hist_next = {hist_reg[PAT_LEN-2:0], x};
    assign fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FW'(1);
    assign hit       = !load && en && (fill_next == FILL_FULL) && (hist_next == pat_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg   <= RST_PAT;
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
        end else if (load) begin
            pat_reg   <= pat_in;
            hist_reg  <= '0;
            fill_reg  <= '0;
            match_reg <= 1'b0;
        end else if (en) begin
            match_reg <= hit;
            // Non-overlapping mode discards the matched bits entirely.
            if (hit && !overlap) begin
                hist_reg <= '0;
                fill_reg <= '0;
            end else begin
                hist_reg <= hist_next;
                fill_reg <= fill_next;
            end
        end else begin
            match_reg <= 1'b0;
        end
    end

    assign match = match_reg;

    sat_counter #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (hit),
        .count (count),
        .ovf   (ovf)
    );

endmodule

// File: tb/tb_seq_match_counter.sv
// Bench for seq_match_counter: saturating and wrapping instances against a queue-based model.
module tb_seq_match_counter;

    localparam int PL = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic          x;
    logic          overlap;
    logic          load;
    logic [PL-1:0] pat_in;
    logic          clr;

    logic          match_s, ovf_s, match_w, ovf_w;
    logic [CW-1:0] count_s, count_w;

    int checks = 0;
    int errors = 0;

    seq_match_counter #(.PAT_LEN(PL), .CNT_W(CW), .RST_PAT(4'b1011), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr(clr), .match(match_s), .count(count_s), .ovf(ovf_s)
    );

    seq_match_counter #(.PAT_LEN(PL), .CNT_W(CW), .RST_PAT(4'b1011), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr(clr), .match(match_w), .count(count_w), .ovf(ovf_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: enabled bits since the last flush, current pattern, hits since clr.
    bit          hq[$];
    logic [PL-1:0] pat_m;
    int          n_hits;
    logic        exp_match;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Outputs are checked on the falling edge, then the model absorbs the inputs
    // that the next rising edge will sample.
    initial begin
        logic [PL-1:0] win;
        logic          hit;
        forever begin
            @(negedge clk);
            if (rst) begin
                hq.delete();
                pat_m     = 4'b1011;
                n_hits    = 0;
                exp_match = 1'b0;
            end else begin
                cmp("model match_s", 32'(match_s), 32'(exp_match));
                cmp("model match_w", 32'(match_w), 32'(exp_match));
                cmp("model count_s", 32'(count_s), (n_hits > 15) ? 32'd15 : 32'(n_hits));
                cmp("model count_w", 32'(count_w), 32'(n_hits % 16));
                cmp("model ovf_s", 32'(ovf_s), 32'(n_hits >= 16));
                cmp("model ovf_w", 32'(ovf_w), 32'(n_hits >= 16));
                hit = 1'b0;
                if (load) begin
                    pat_m = pat_in;
                    hq.delete();
                    exp_match = 1'b0;
                end else if (en) begin
                    hq.push_back(x);
                    if (hq.size() > PL) void'(hq.pop_front());
                    win = '0;
                    foreach (hq[i]) win = {win[PL-2:0], hq[i]};
                    hit = (hq.size() == PL) && (win == pat_m);
                    exp_match = hit;
                    if (hit && !overlap) hq.delete();
                end else begin
                    exp_match = 1'b0;
                end
                if (clr) n_hits = 0;
                else if (hit) n_hits++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic drive(input logic b, input logic e, input logic ld, input logic cl,
                         input logic [PL-1:0] p);
        x      = b;
        en     = e;
        load   = ld;
        clr    = cl;
        pat_in = p;
        @(posedge clk);
        #2;
    endtask

    task automatic bit_chk(input logic b, input logic exp_m, input string name);
        drive(b, 1'b1, 1'b0, 1'b0, 4'b0000);
        chk(name, 32'(match_s), 32'(exp_m));
    endtask

    task automatic reload(input logic [PL-1:0] p, input logic cl);
        drive(1'b1, 1'b1, 1'b1, cl, p);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b1;
        load = 1'b0; pat_in = '0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset match", 32'(match_s), 32'd0);
        chk("reset count", 32'(count_s), 32'd0);
        chk("reset ovf", 32'(ovf_s), 32'd0);
        rst = 1'b0;

        // Overlapping: 1011011 hits at bits 4 and 7.
        overlap = 1'b1;
        reload(4'b1011, 1'b1);
        bit_chk(1, 0, "t1 b1"); bit_chk(0, 0, "t1 b2"); bit_chk(1, 0, "t1 b3");
        bit_chk(1, 1, "t1 b4"); bit_chk(0, 0, "t1 b5"); bit_chk(1, 0, "t1 b6");
        bit_chk(1, 1, "t1 b7");
        chk("t1 count", 32'(count_s), 32'd2);
        chk("t1 ovf", 32'(ovf_s), 32'd0);

        // Non-overlapping: only the first hit.
        overlap = 1'b0;
        reload(4'b1011, 1'b1);
        bit_chk(1, 0, "t2 b1"); bit_chk(0, 0, "t2 b2"); bit_chk(1, 0, "t2 b3");
        bit_chk(1, 1, "t2 b4"); bit_chk(0, 0, "t2 b5"); bit_chk(1, 0, "t2 b6");
        bit_chk(1, 0, "t2 b7");
        chk("t2 count", 32'(count_w), 32'd1);

        // Disabled cycles must not enter history.
        overlap = 1'b1;
        reload(4'b1011, 1'b1);
        drive(1, 1, 0, 0, 4'b0); drive(0, 1, 0, 0, 4'b0);
        drive(1, 0, 0, 0, 4'b0);
        chk("t3 gap match", 32'(match_s), 32'd0);
        drive(1, 1, 0, 0, 4'b0); drive(0, 0, 0, 0, 4'b0);
        drive(1, 1, 0, 0, 4'b0);
        chk("t3 match", 32'(match_s), 32'd1);
        chk("t3 count", 32'(count_s), 32'd1);

        // Seventeen hits: saturate at 15 vs wrap to 1, both flag overflow.
        reload(4'b1011, 1'b1);
        drive(1, 1, 0, 0, 4'b0); drive(0, 1, 0, 0, 4'b0);
        drive(1, 1, 0, 0, 4'b0); drive(1, 1, 0, 0, 4'b0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 4'b0); drive(1, 1, 0, 0, 4'b0); drive(1, 1, 0, 0, 4'b0);
        end
        chk("t4 count sat", 32'(count_s), 32'd15);
        chk("t4 ovf sat", 32'(ovf_s), 32'd1);
        chk("t4 count wrap", 32'(count_w), 32'd1);
        chk("t4 ovf wrap", 32'(ovf_w), 32'd1);
        drive(0, 0, 0, 1, 4'b0);
        chk("t4 clr count sat", 32'(count_s), 32'd0);
        chk("t4 clr ovf sat", 32'(ovf_s), 32'd0);
        chk("t4 clr count wrap", 32'(count_w), 32'd0);
        chk("t4 clr ovf wrap", 32'(ovf_w), 32'd0);

        // Load mid-stream flushes history and switches pattern.
        reload(4'b1011, 1'b1);
        bit_chk(1, 0, "t5 a1"); bit_chk(0, 0, "t5 a2"); bit_chk(1, 0, "t5 a3");
        reload(4'b0110, 1'b0);
        bit_chk(1, 0, "t5 after load");
        bit_chk(0, 0, "t5 b1"); bit_chk(1, 0, "t5 b2"); bit_chk(1, 0, "t5 b3");
        bit_chk(0, 1, "t5 b4"); bit_chk(1, 0, "t5 b5"); bit_chk(1, 0, "t5 b6");
        bit_chk(0, 1, "t5 b7");
        chk("t5 count", 32'(count_s), 32'd2);

        // Asynchronous reset mid-pattern clears outputs without waiting for a clock.
        bit_chk(1, 0, "t6 c1"); bit_chk(0, 0, "t6 c2"); bit_chk(1, 0, "t6 c3");
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6 rst count", 32'(count_s), 32'd0);
        chk("t6 rst match", 32'(match_s), 32'd0);
        chk("t6 rst ovf", 32'(ovf_w), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        bit_chk(1, 0, "t6 d1"); bit_chk(0, 0, "t6 d2"); bit_chk(1, 0, "t6 d3");
        bit_chk(1, 1, "t6 default pattern");
        chk("t6 count", 32'(count_s), 32'd1);

        // clr coincident with a hit: pulse still fires, count ends at zero.
        bit_chk(0, 0, "t6 e1"); bit_chk(1, 0, "t6 e2");
        drive(1, 1, 0, 1, 4'b0);
        chk("t6 clr hit match", 32'(match_s), 32'd1);
        chk("t6 clr hit count", 32'(count_s), 32'd0);
        drive(0, 0, 0, 0, 4'b0);
        chk("t6 clr hit after", 32'(count_w), 32'd0);

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(63) == 0) overlap = ~overlap;
            drive(1'($urandom), ($urandom_range(3) != 0),
                  ($urandom_range(199) == 0), ($urandom_range(399) == 0),
                  4'($urandom));
        end
        drive(0, 0, 0, 0, 4'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
